data_mem_ctrl: RTL and testbench

- Word-organised data memory with a request/ready handshake and a programmable access latency.
- Sits in the MEM stage directly upstream of the load extender.
- For loads it returns the raw, unshifted 32-bit word; the extender selects bytes or halfwords from addr[1:0].
- For stores it performs byte-lane alignment and partial-word writes (SW/SH/SB), and it flags misaligned accesses.

---
 rtl/data_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Word-organised data memory for the MEM stage with a req/ready handshake and
//   a programmable access latency. Loads return the raw 32-bit word (byte or
//   halfword selection is left to the downstream load extender). Stores are
//   lane-aligned here and written with byte enables. Misaligned accesses and
//   the reserved size complete early with addr_err and have no side effects.
//
// Parameters
//   ADDR_WIDTH  : word-address bits, array depth is 2**ADDR_WIDTH words
//   WAIT_CYCLES : extra wait cycles before each access completes (0 is legal)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (memory contents kept)
//   req      in   access request, only looked at while idle
//   we       in   1 = store, 0 = load
//   size     in   00 word, 01 half, 10 byte, 11 reserved
//   addr     in   byte address; bits above the word index are ignored
//   wdata    in   right-justified store data
//   rdata    out  raw memory word of the last successful load
//   ready    out  one-cycle completion pulse
//   busy     out  high while a request is in flight
//   addr_err out  qualified by ready: misaligned access or reserved size
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misalignment / reserved-size detection.
    function automatic logic is_bad_access(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            2'b00:   bad = (lo != 2'b00);
            2'b01:   bad = lo[0];
            2'b10:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables and lane-aligned data for a store: {be[3:0], data[31:0]}.
    function automatic logic [35:0] align_store(input logic [1:0] sz, input logic [1:0] lo,
                                                input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] data;
        case (sz)
            2'b00: begin
                be   = 4'b1111;
                data = wd;
            end
            2'b01: begin
                if (lo[1]) begin
                    be   = 4'b1100;
                    data = {wd[15:0], 16'h0000};
                end else begin
                    be   = 4'b0011;
                    data = {16'h0000, wd[15:0]};
                end
            end
            2'b10: begin
                // Byte replicated into all lanes; only the enabled lane is written.
                be   = 4'b0001 << lo;
                data = {4{wd[7:0]}};
            end
            default: begin
                be   = 4'b0000;
                data = 32'h0000_0000;
            end
        endcase
        return {be, data};
    endfunction

    logic [31:0]           mem [0:DEPTH-1];

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  we_r;
    logic [1:0]            size_r;
    logic [ADDR_WIDTH+1:0] addr_r;
    logic [31:0]           wdata_r;

    logic                  latch_s, access_s, err_s, ready_s, busy_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic [35:0]           store_s;
    logic [3:0]            be_s;
    logic [31:0]           wd_s;
    logic                  unused_addr_s;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];

    // Word index and lane-aligned store data from the latched request.
    always_comb begin
        idx_s   = addr_r[ADDR_WIDTH+1:2];
        store_s = align_store(size_r, addr_r[1:0], wdata_r);
        be_s    = store_s[35:32];
        wd_s    = store_s[31:0];
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        latch_s  = 1'b0;
        access_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    latch_s = 1'b1;
                    if (is_bad_access(size, addr[1:0])) begin
                        state_s = ST_RESP;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_W'(WAIT_CYCLES);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    access_s = 1'b1;
                    state_s  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        ready_s = (state_s == ST_RESP);
        busy_s  = (state_s != ST_IDLE);
    end

    // State, counter, registered outputs and load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            ready    <= 1'b0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ready    <= ready_s;
            busy     <= busy_s;
            addr_err <= err_s;
            if (access_s && !we_r) begin
                rdata <= mem[idx_s];
            end
        end
    end

    // Request capture; inputs are only sampled when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= {(ADDR_WIDTH+2){1'b0}};
            wdata_r <= 32'h0000_0000;
        end else if (latch_s) begin
            we_r    <= we;
            size_r  <= size;
            addr_r  <= addr[ADDR_WIDTH+1:0];
            wdata_r <= wdata;
        end
    end

    // Array write with byte enables; contents survive reset, an aborted store never commits.
    always_ff @(posedge clk) begin
        if (!rst && access_s && we_r) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem[idx_s][8*k +: 8] <= wd_s[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Two instances: unit 0 with the default geometry (ADDR_WIDTH=10,
//   WAIT_CYCLES=2) and unit 1 with ADDR_WIDTH=4, WAIT_CYCLES=0. A byte-level
//   memory model per unit predicts rdata, latency and addr_err for directed
//   and random accesses.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 16 words per unit plus last loaded word.
    logic [31:0] mdl [2][16];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .addr_err(err_a)
    );

    data_mem_ctrl #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .addr_err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int u);
        return (u == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_err(input int u);
        return (u == 0) ? err_a : err_b;
    endfunction

    function automatic logic [31:0] get_rdata(input int u);
        return (u == 0) ? rdata_a : rdata_b;
    endfunction

    task automatic set_req(input int u, input logic v);
        if (u == 0) req_a = v;
        else        req_b = v;
    endtask

    // One complete transaction with model update and timing checks.
    // noise=1 keeps req high with garbage inputs while the request is in flight.
    task automatic access(input int u, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input bit noise);
        bit err;
        int idx, nb, pos, lat, exp_lat;
        err = (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
        idx = (u == 0) ? int'((a >> 2) & 32'd1023) : int'((a >> 2) & 32'd15);
        exp_lat = err ? 1 : ((u == 0) ? 4 : 2);
        if (!err) begin
            if (w) begin
                nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
                for (int i = 0; i < nb; i++) begin
                    pos = int'(a[1:0]) + i;
                    mdl[u][idx][8*pos +: 8] = d[8*i +: 8];
                end
            end else begin
                last_rd[u] = mdl[u][idx];
            end
        end
        @(negedge clk);
        we = w; size = sz; addr = a; wdata = d;
        set_req(u, 1'b1);
        @(negedge clk);
        set_req(u, 1'b0);
        check_eq("busy_after_accept", {31'd0, get_busy(u)}, 32'd1);
        lat = 1;
        while (!get_ready(u) && lat < 40) begin
            if (noise) begin
                we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
                set_req(u, 1'b1);
            end
            @(negedge clk);
            lat++;
        end
        set_req(u, 1'b0);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("ready", {31'd0, get_ready(u)}, 32'd1);
        check_eq("busy_resp", {31'd0, get_busy(u)}, 32'd1);
        check_eq("addr_err", {31'd0, get_err(u)}, {31'd0, err});
        check_eq("rdata", get_rdata(u), last_rd[u]);
        @(negedge clk);
        check_eq("ready_pulse_end", {31'd0, get_ready(u)}, 32'd0);
        check_eq("busy_idle", {31'd0, get_busy(u)}, 32'd0);
        check_eq("err_low", {31'd0, get_err(u)}, 32'd0);
    endtask

    initial begin
        int seen;
        int u, idx;
        logic [1:0] sz, lo;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        check_eq("rst_ready", {31'd0, ready_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_err", {31'd0, err_a}, 32'd0);
        check_eq("rst_rdata", rdata_a, 32'h0);

        // Give every modelled word a known value.
        for (int un = 0; un < 2; un++) begin
            for (int w = 0; w < 16; w++) begin
                access(un, 1'b1, 2'b00, 32'(w) << 2, $urandom, 1'b0);
            end
        end

        // Word store and load.
        access(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
        check_eq("lw_deadbeef", rdata_a, 32'hDEADBEEF);

        // Partial-word stores.
        access(0, 1'b1, 2'b00, 32'h20, 32'h11223344, 1'b0);
        access(0, 1'b1, 2'b10, 32'h21, 32'hFFFF_FFAA, 1'b0);
        access(0, 1'b1, 2'b01, 32'h22, 32'hFFFF_5566, 1'b0);
        access(0, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0);
        check_eq("lw_merged", rdata_a, 32'h5566AA44);

        // Error accesses: early ready, no side effects.
        access(0, 1'b1, 2'b01, 32'h23, 32'h0000_BBBB, 1'b0);
        access(0, 1'b0, 2'b00, 32'h22, 32'h0, 1'b0);
        access(0, 1'b1, 2'b11, 32'h20, 32'hCCCC_CCCC, 1'b0);
        check_eq("rdata_after_err", rdata_a, 32'h5566AA44);
        access(0, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0);
        check_eq("mem_after_err", rdata_a, 32'h5566AA44);

        // Input noise while busy.
        access(0, 1'b1, 2'b00, 32'h24, 32'hCAFE_F00D, 1'b1);
        access(0, 1'b0, 2'b00, 32'h24, 32'h0, 1'b1);
        check_eq("noise_load", rdata_a, 32'hCAFE_F00D);

        // Reset on the edge that would commit a store.
        access(0, 1'b1, 2'b00, 32'h30, 32'h0, 1'b0);
        @(negedge clk);
        we = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'hFFFF_FFFF; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        last_rd[0] = 32'h0;
        check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
        check_eq("abort_rdata", rdata_a, 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ready_a) seen++;
            @(negedge clk);
        end
        check_eq("abort_no_ready", 32'(seen), 32'd0);
        access(0, 1'b0, 2'b00, 32'h30, 32'h0, 1'b0);
        check_eq("abort_no_write", rdata_a, 32'h0);

        // Zero-wait, 16-word unit with address wrap.
        access(1, 1'b1, 2'b00, 32'h40, 32'h12345678, 1'b0);
        access(1, 1'b0, 2'b00, 32'h00, 32'h0, 1'b0);
        check_eq("wrap_load", rdata_b, 32'h12345678);

        // Random mix on both units.
        for (int t = 0; t < 300; t++) begin
            u   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            sz  = 2'($urandom);
            lo  = 2'($urandom);
            if (u == 0) a = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | {30'd0, lo};
            else        a = ($urandom & 32'hFFFF_FFC0) | (32'(idx) << 2) | {30'd0, lo};
            access(u, 1'($urandom), sz, a, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
